// File: rtl/counter_sweep_ctrl_pkg.sv
// Shared widths and FSM encoding for the triangle sweep sequencer.
package counter_sweep_ctrl_pkg;

    localparam int N_DEF  = 8;
    localparam int SW_DEF = 8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_UP   = 3'd2,
        S_DOWN = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/counter_sweep_ctrl_if.sv
// Host-side control and status bundle of the sweep sequencer.
interface counter_sweep_ctrl_if
    import counter_sweep_ctrl_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int SW = SW_DEF
) ();

    logic          start;
    logic          pause;
    logic          abort;
    logic [N-1:0]  start_val;
    logic [N-1:0]  limit_lo;
    logic [N-1:0]  limit_hi;
    logic [SW-1:0] num_sweeps;
    logic [N-1:0]  q;
    logic          dir;
    logic          busy;
    logic          done;
    logic          err;
    logic [SW-1:0] sweep_cnt;

    modport master (
        output start, pause, abort,
        output start_val, limit_lo, limit_hi, num_sweeps,
        input  q, dir, busy, done, err, sweep_cnt
    );

    modport slave (
        input  start, pause, abort,
        input  start_val, limit_lo, limit_hi, num_sweeps,
        output q, dir, busy, done, err, sweep_cnt
    );

endinterface

// File: rtl/counter_sweep_ctrl_counter.sv
// Universal up/down binary counter: clear > load > count.
module universal_binary_counter
    import counter_sweep_ctrl_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_syn_clr,
    input  logic         i_load,
    input  logic         i_en,
    input  logic         i_up,
    input  logic [N-1:0] i_d,
    output logic         o_max_tick,
    output logic         o_min_tick,
    output logic [N-1:0] o_q
);

    logic [N-1:0] r_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_q <= '0;
        else if (i_syn_clr)
            r_q <= '0;
        else if (i_load)
            r_q <= i_d;
        else if (i_en)
            r_q <= i_up ? r_q + N'(1) : r_q - N'(1);
    end

    assign o_q        = r_q;
    assign o_max_tick = (r_q == '1);
    assign o_min_tick = (r_q == '0);

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Triangle sweep sequencer: drives the counter lo->hi->lo per sweep.
module counter_sweep_ctrl
    import counter_sweep_ctrl_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int SW = SW_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    counter_sweep_ctrl_if.slave  bus
);

    state_t        r_state;
    state_t        w_next;
    logic [N-1:0]  r_lo;
    logic [N-1:0]  r_hi;
    logic [N-1:0]  r_sv;
    logic [SW-1:0] r_num;
    logic [SW-1:0] r_sweep_cnt;

    logic          w_cfg_ok;
    logic          w_accept;
    logic          w_at_hi;
    logic          w_at_lo;
    logic          w_last;
    logic          w_load;
    logic          w_clr;
    logic          w_en;
    logic          w_up;
    logic          w_sweep_inc;
    logic [N-1:0]  w_q;
    logic [1:0]    w_unused_ticks;

    assign w_cfg_ok = (bus.limit_lo < bus.limit_hi)
                   && (bus.limit_lo <= bus.start_val)
                   && (bus.start_val <= bus.limit_hi);
    assign w_accept = (r_state == S_IDLE) && bus.start && w_cfg_ok;
    assign w_at_hi  = (w_q == r_hi);
    assign w_at_lo  = (w_q == r_lo);
    // num_sweeps of zero means free-running until abort
    assign w_last   = (r_num != '0)
                   && ((r_sweep_cnt + SW'(1)) == r_num);

    always_comb begin
        w_next      = r_state;
        w_load      = 1'b0;
        w_clr       = 1'b0;
        w_en        = 1'b0;
        w_up        = 1'b0;
        w_sweep_inc = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept)
                    w_next = S_LOAD;
            end
            S_LOAD: begin
                if (bus.abort) begin
                    w_clr  = 1'b1;
                    w_next = S_IDLE;
                end else begin
                    w_load = 1'b1;
                    w_next = S_UP;
                end
            end
            S_UP: begin
                if (bus.abort) begin
                    w_clr  = 1'b1;
                    w_next = S_IDLE;
                end else if (!bus.pause) begin
                    w_en = 1'b1;
                    w_up = !w_at_hi;
                    if (w_at_hi)
                        w_next = S_DOWN;
                end
            end
            S_DOWN: begin
                if (bus.abort) begin
                    w_clr  = 1'b1;
                    w_next = S_IDLE;
                end else if (!bus.pause) begin
                    if (!w_at_lo) begin
                        w_en = 1'b1;
                    end else begin
                        w_sweep_inc = 1'b1;
                        if (w_last) begin
                            w_next = S_DONE;
                        end else begin
                            w_en   = 1'b1;
                            w_up   = 1'b1;
                            w_next = S_UP;
                        end
                    end
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lo  <= '0;
            r_hi  <= '0;
            r_sv  <= '0;
            r_num <= '0;
        end else if (w_accept) begin
            r_lo  <= bus.limit_lo;
            r_hi  <= bus.limit_hi;
            r_sv  <= bus.start_val;
            r_num <= bus.num_sweeps;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_sweep_cnt <= '0;
        else if (w_accept)
            r_sweep_cnt <= '0;
        else if (w_sweep_inc)
            r_sweep_cnt <= r_sweep_cnt + SW'(1);
    end

    universal_binary_counter #(.N(N)) u_cnt (
        .i_clk      (clk),
        .i_rst      (reset),
        .i_syn_clr  (w_clr),
        .i_load     (w_load),
        .i_en       (w_en),
        .i_up       (w_up),
        .i_d        (r_sv),
        .o_max_tick (w_unused_ticks[0]),
        .o_min_tick (w_unused_ticks[1]),
        .o_q        (w_q)
    );

    assign bus.q         = w_q;
    assign bus.dir       = (r_state != S_DOWN);
    assign bus.busy      = (r_state == S_LOAD) || (r_state == S_UP)
                        || (r_state == S_DOWN);
    assign bus.done      = (r_state == S_DONE);
    assign bus.err       = (r_state == S_IDLE) && bus.start && !w_cfg_ok;
    assign bus.sweep_cnt = r_sweep_cnt;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl: directed and random sweeps vs a ramp model.
module tb_counter_sweep_ctrl;
    import counter_sweep_ctrl_pkg::*;

    localparam int N  = N_DEF;
    localparam int SW = SW_DEF;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    counter_sweep_ctrl_if #(.N(N), .SW(SW)) bus ();

    counter_sweep_ctrl #(.N(N), .SW(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int q;
        int dir;
        int cnt;
    } step_t;

    step_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Expected (q, dir, sweep_cnt) for each cycle after LOAD.
    task automatic build(input int lo, input int hi, input int sv,
                         input int ms);
        int cnt;
        cnt = 0;
        exp_q.delete();
        for (int v = sv; v <= hi; v++) exp_q.push_back('{v, 1, cnt});
        for (int s = 0; s < ms; s++) begin
            for (int w = hi - 1; w >= lo; w--)
                exp_q.push_back('{w, 0, cnt});
            cnt = (cnt + 1) % (1 << SW);
            if (s == ms - 1) break;
            for (int w = lo + 1; w <= hi; w++)
                exp_q.push_back('{w, 1, cnt});
        end
    endtask

    task automatic do_start(input int lo, input int hi, input int sv,
                            input int num, input int exp_err,
                            input string tag);
        @(negedge clk);
        bus.limit_lo   = N'(lo);
        bus.limit_hi   = N'(hi);
        bus.start_val  = N'(sv);
        bus.num_sweeps = SW'(num);
        bus.start      = 1'b1;
        #1;
        chk({tag, "_err"}, 32'(bus.err), 32'(exp_err));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_for(input int qv, input int dv, input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (int'(bus.q) == qv && int'(bus.dir) == dv) found = 1'b1;
        end
        chk({tag, "_reach"}, 32'(found), 32'd1);
    endtask

    task automatic run(input int lo, input int hi, input int sv,
                       input int num, input string tag);
        int   ms;
        step_t e;
        ms = (num == 0) ? 257 : num;
        build(lo, hi, sv, ms);
        do_start(lo, hi, sv, num, 0, tag);
        chk({tag, "_load_busy"}, 32'(bus.busy), 32'd1);
        foreach (exp_q[i]) begin
            // scramble unlatched inputs; a start mid-run must be ignored
            bus.limit_lo   = N'($urandom);
            bus.limit_hi   = N'($urandom);
            bus.start_val  = N'($urandom);
            bus.num_sweeps = SW'($urandom);
            bus.start      = (i == 2);
            @(negedge clk);
            e = exp_q[i];
            chk({tag, "_q"}, 32'(bus.q), 32'(e.q));
            chk({tag, "_dir"}, 32'(bus.dir), 32'(e.dir));
            chk({tag, "_cnt"}, 32'(bus.sweep_cnt), 32'(e.cnt));
            chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
            chk({tag, "_done"}, 32'(bus.done), 32'd0);
            chk({tag, "_noerr"}, 32'(bus.err), 32'd0);
        end
        bus.start = 1'b0;
        if (num != 0) begin
            @(negedge clk);
            chk({tag, "_done1"}, 32'(bus.done), 32'd1);
            chk({tag, "_done_busy"}, 32'(bus.busy), 32'd0);
            chk({tag, "_done_q"}, 32'(bus.q), 32'(lo));
            chk({tag, "_done_cnt"}, 32'(bus.sweep_cnt),
                32'(num % (1 << SW)));
            @(negedge clk);
            chk({tag, "_done0"}, 32'(bus.done), 32'd0);
            chk({tag, "_idle_q"}, 32'(bus.q), 32'(lo));
        end else begin
            bus.abort = 1'b1;
            @(negedge clk);
            bus.abort = 1'b0;
            chk({tag, "_ab_q"}, 32'(bus.q), 32'd0);
            chk({tag, "_ab_busy"}, 32'(bus.busy), 32'd0);
            chk({tag, "_ab_done"}, 32'(bus.done), 32'd0);
            chk({tag, "_ab_cnt"}, 32'(bus.sweep_cnt),
                32'(exp_q[$].cnt));
        end
    endtask

    initial begin
        int lo, hi, sv, num, ok;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.pause      = 1'b0;
        bus.abort      = 1'b0;
        bus.start_val  = '0;
        bus.limit_lo   = '0;
        bus.limit_hi   = '0;
        bus.num_sweeps = '0;

        @(negedge clk);
        chk("rst_q", 32'(bus.q), 32'd0);
        chk("rst_dir", 32'(bus.dir), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_cnt", 32'(bus.sweep_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run(1, 4, 2, 1, "basic");
        run(0, 7, 0, 2, "multi");
        run(3, 9, 3, 1, "sv_lo");
        run(3, 9, 9, 2, "sv_hi");

        // pause mid-ramp and at the upper turn, then abort while paused
        do_start(0, 7, 3, 3, 0, "pause");
        wait_for(5, 1, "p5");
        bus.pause = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("p5_hold_q", 32'(bus.q), 32'd5);
            chk("p5_hold_dir", 32'(bus.dir), 32'd1);
        end
        bus.pause = 1'b0;
        @(negedge clk);
        chk("p5_resume", 32'(bus.q), 32'd6);
        wait_for(7, 1, "p7");
        bus.pause = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("p7_hold_q", 32'(bus.q), 32'd7);
            chk("p7_hold_dir", 32'(bus.dir), 32'd1);
        end
        bus.pause = 1'b0;
        @(negedge clk);
        chk("p7_turn_q", 32'(bus.q), 32'd6);
        chk("p7_turn_dir", 32'(bus.dir), 32'd0);
        wait_for(3, 0, "a3a");
        wait_for(3, 0, "a3b");
        chk("a3_cnt", 32'(bus.sweep_cnt), 32'd1);
        bus.abort = 1'b1;
        bus.pause = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.pause = 1'b0;
        chk("abort_q", 32'(bus.q), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_dir", 32'(bus.dir), 32'd1);
        chk("abort_cnt", 32'(bus.sweep_cnt), 32'd1);
        repeat (2) begin
            @(negedge clk);
            chk("abort_nodone", 32'(bus.done), 32'd0);
            chk("abort_idle", 32'(bus.busy), 32'd0);
            chk("abort_hold_q", 32'(bus.q), 32'd0);
        end

        do_start(5, 5, 5, 1, 1, "inv_eq");
        #1;
        chk("inv_eq_busy", 32'(bus.busy), 32'd0);
        chk("inv_eq_q", 32'(bus.q), 32'd0);
        chk("inv_eq_err0", 32'(bus.err), 32'd0);
        do_start(1, 4, 6, 1, 1, "inv_sv");
        chk("inv_sv_busy", 32'(bus.busy), 32'd0);
        do_start(6, 2, 3, 1, 1, "inv_order");
        chk("inv_order_busy", 32'(bus.busy), 32'd0);

        // asynchronous reset between clock edges during UP
        do_start(0, 7, 0, 0, 0, "rst");
        wait_for(4, 1, "r4a");
        wait_for(4, 1, "r4b");
        chk("r4_cnt", 32'(bus.sweep_cnt), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_q", 32'(bus.q), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_dir", 32'(bus.dir), 32'd1);
        chk("arst_cnt", 32'(bus.sweep_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run(2, 6, 4, 1, "after_rst");

        run(0, 1, 0, 0, "wrap");

        repeat (8) begin
            lo  = int'($urandom_range(30, 0));
            hi  = lo + 1 + int'($urandom_range(8, 0));
            sv  = int'($urandom_range(hi, lo));
            num = int'($urandom_range(3, 1));
            run(lo, hi, sv, num, "rand");
        end

        repeat (8) begin
            lo = int'($urandom_range(15, 0));
            hi = int'($urandom_range(15, 0));
            sv = int'($urandom_range(15, 0));
            ok = (lo < hi && lo <= sv && sv <= hi) ? 1 : 0;
            do_start(lo, hi, sv, 1, 1 - ok, "rcfg");
            chk("rcfg_busy", 32'(bus.busy), 32'(ok));
            if (ok == 1) begin
                bus.abort = 1'b1;
                @(negedge clk);
                bus.abort = 1'b0;
                chk("rcfg_ab_q", 32'(bus.q), 32'd0);
                chk("rcfg_ab_busy", 32'(bus.busy), 32'd0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
